esn_sequencer: RTL and testbench
================================

Name: esn_sequencer

Overview:
Parametrised control FSM for the integer echo state network. It sequences NUM_STAGES reservoir layers and then the interpreter (readout) for a programmable number of time steps per run. Each unit is enabled by a one-hot level enable, and the sequencer waits for that unit's ready before moving on. Adds step counting, abort, a per-phase watchdog and done/error status that the single-layer handler does not have.

Parameters:
NUM_STAGES, 2, number of reservoir layers chained per time step (1..16)
STEP_W, 16, width of the time-step counter and of iNumSteps
TIMEOUT_W, 8, width of the watchdog counter; a wait of 2^TIMEOUT_W-1 cycles on one phase is a timeout
TIMEOUT_EN, 1, 1 enables the watchdog; 0 disables it (oTimeout tied 0)

Ports:
iClk  input  1  system clock, all state on rising edge
iRst_n  input  1  asynchronous active-low reset
iStart  input  1  start a run; sampled only in IDLE or ERR
iAbort  input  1  abort the current run
iNumSteps  input  STEP_W  time steps per run, latched on accepted start
iResRdy  input  NUM_STAGES  bit k: reservoir layer k finished current step
iIntRdy  input  1  interpreter finished current step
oEnReserv  output  NUM_STAGES  one-hot enable of active reservoir layer (all 0 otherwise)
oEnInterpreter  output  1  interpreter enable
oStage  output  SW=max(1,clog2(NUM_STAGES))  index of active/last reservoir layer
oStep  output  STEP_W  current time-step index (0-based)
oBusy  output  1  run in progress
oDone  output  1  one-cycle pulse on normal run completion
oTimeout  output  1  sticky watchdog error flag

Behaviour:
- Reset (async, iRst_n=0): state IDLE; oEnReserv=0, oEnInterpreter=0, oStage=0, oStep=0, oBusy=0, oDone=0, oTimeout=0, watchdog=0, latched step count=0. All outputs are registered.
- States: IDLE, RES, INTERP, DONE, ERR.
- IDLE/ERR with iStart=1 at edge t:
  - Latch iNumSteps and clear oTimeout.
  - If iNumSteps=0: go to DONE. In cycle t+1, oDone=1 and no enable is ever raised.
  - Otherwise: go to RES. In cycle t+1, oEnReserv=1<<0, oStage=0, oStep=0, oBusy=1.
- iStart is ignored while oBusy=1.
- RES, stage k: hold oEnReserv[k] while iResRdy[k]=0. Other iResRdy bits are ignored.
  - iResRdy[k]=1 at edge, k<NUM_STAGES-1: next cycle oEnReserv=1<<(k+1) and oStage=k+1. No gap cycle.
  - iResRdy[k]=1 at edge, k=NUM_STAGES-1: next cycle oEnReserv=0 and oEnInterpreter=1 (state INTERP).
- INTERP: hold oEnInterpreter=1 while iIntRdy=0. On iIntRdy=1 at edge:
  - If oStep+1 = latched count: go to DONE. Next cycle oEnInterpreter=0, oDone=1, oBusy=0.
  - Otherwise: go to RES stage 0. Next cycle oStep=oStep+1 (modulo 2^STEP_W) and oEnReserv=1<<0.
- DONE: lasts exactly one cycle, then IDLE. oStep keeps the final index.
- Watchdog:
  - Clears on every phase entry (each stage change, entry to INTERP, new step).
  - Increments each cycle spent in RES/INTERP without the awaited ready.
  - On reaching 2^TIMEOUT_W-1 with ready still low: go to ERR. Next cycle all enables 0, oBusy=0, oTimeout=1 (sticky until an accepted start or reset).
- Abort: iAbort=1 in RES/INTERP gives IDLE next cycle, all enables 0, oBusy=0, no oDone. oStep and oStage hold. iAbort in IDLE/DONE/ERR has no effect.
- Priority at one edge: reset > iAbort > awaited ready > watchdog expiry.
  - Ready on the expiry cycle counts as success.
  - iStart and iAbort together in IDLE: start is accepted (abort has no effect in IDLE).
- Reset mid-run: immediate return to the reset values, regardless of state.
- Illegal state encoding: go to IDLE with all enables 0.

Test Plan:
- NUM_STAGES=2, iNumSteps=3, each ready asserted 2 cycles after its enable -> enable order R0,R1,I repeated 3 times; oStep=0,1,2; single oDone pulse one cycle after the third iIntRdy; oBusy low afterwards.
- iNumSteps=0, iStart pulse -> oDone=1 in the next cycle; oEnReserv and oEnInterpreter never assert; oBusy stays 0.
- TIMEOUT_W=4, iResRdy[1] held 0 -> oEnReserv[1] high 15 cycles, then all enables 0 and oTimeout=1. A new iStart clears oTimeout and restarts at R0 with oStep=0.
- Ready asserted on the exact expiry cycle -> no timeout; sequence continues normally.
- iAbort during INTERP at step 1 -> next cycle enables 0, oBusy=0, oStep=1 held, no oDone. iStart during the run (before the abort) is ignored.
- iRst_n pulsed low asynchronously mid-RES at step 5 -> all outputs return to the reset values without waiting for iClk; next iStart runs from step 0.

Source files
------------

// File: rtl/esn_sequencer.sv
// Run sequencer for the integer echo state network: steps NUM_STAGES reservoir layers, then the readout, for N time steps per run.
// Outputs are registered; each phase waits on its unit's ready, with abort and a per-phase watchdog.
module esn_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int STEP_W     = 16,
  parameter int TIMEOUT_W  = 8,
  parameter int TIMEOUT_EN = 1,
  localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic                  iAbort,
  input  logic [STEP_W-1:0]     iNumSteps,
  input  logic [NUM_STAGES-1:0] iResRdy,
  input  logic                  iIntRdy,
  output logic [NUM_STAGES-1:0] oEnReserv,
  output logic                  oEnInterpreter,
  output logic [SW-1:0]         oStage,
  output logic [STEP_W-1:0]     oStep,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oTimeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RES    = 3'd1,
    S_INTERP = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [SW-1:0]        LAST_STAGE = SW'(NUM_STAGES - 1);
  // Last watchdog value before expiry: the phase has then waited 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] WD_LAST    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                  state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [STEP_W-1:0]       num_q, num_d;
  logic [TIMEOUT_W-1:0]    wd_q, wd_d;
  logic [NUM_STAGES-1:0]   en_res_q, en_res_d;
  logic                    en_int_q, en_int_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    res_rdy;
  logic                    expire;

  assign res_rdy = iResRdy[stage_q];
  assign expire  = (TIMEOUT_EN != 0) && (wd_q == WD_LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      step_q    <= '0;
      num_q     <= '0;
      wd_q      <= '0;
      en_res_q  <= '0;
      en_int_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      step_q    <= step_d;
      num_q     <= num_d;
      wd_q      <= wd_d;
      en_res_q  <= en_res_d;
      en_int_q  <= en_int_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    step_d    = step_q;
    num_d     = num_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (iStart) begin
          num_d     = iNumSteps;
          timeout_d = 1'b0;
          stage_d   = '0;
          step_d    = '0;
          wd_d      = '0;
          state_d   = (iNumSteps == '0) ? S_DONE : S_RES;
        end
      end
      S_RES: begin
        if (iAbort) begin
          state_d = S_IDLE;
        end else if (res_rdy) begin
          wd_d = '0;
          if (stage_q == LAST_STAGE) state_d = S_INTERP;
          else                       stage_d = stage_q + SW'(1);
        end else if (expire) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      S_INTERP: begin
        if (iAbort) begin
          state_d = S_IDLE;
        end else if (iIntRdy) begin
          wd_d = '0;
          if (step_q + STEP_W'(1) == num_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RES;
            stage_d = '0;
            step_d  = step_q + STEP_W'(1);
          end
        end else if (expire) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded from the next state so every output is a flop.
    en_res_d = (state_d == S_RES) ? (NUM_STAGES'(1) << stage_d) : '0;
    en_int_d = (state_d == S_INTERP);
    busy_d   = (state_d == S_RES) || (state_d == S_INTERP);
    done_d   = (state_d == S_DONE);
  end

  assign oEnReserv      = en_res_q;
  assign oEnInterpreter = en_int_q;
  assign oStage         = stage_q;
  assign oStep          = step_q;
  assign oBusy          = busy_q;
  assign oDone          = done_q;
  assign oTimeout       = timeout_q;

endmodule

// File: tb/tb_esn_sequencer.sv
// Directed bench for esn_sequencer: 2 stages, 4-bit watchdog (15-cycle phase limit).
module tb_esn_sequencer;

  logic        iClk;
  logic        iRst_n;
  logic        iStart;
  logic        iAbort;
  logic [15:0] iNumSteps;
  logic [1:0]  iResRdy;
  logic        iIntRdy;
  logic [1:0]  oEnReserv;
  logic        oEnInterpreter;
  logic [0:0]  oStage;
  logic [15:0] oStep;
  logic        oBusy;
  logic        oDone;
  logic        oTimeout;

  int errors = 0;
  int checks = 0;

  esn_sequencer #(
    .NUM_STAGES(2),
    .STEP_W(16),
    .TIMEOUT_W(4),
    .TIMEOUT_EN(1)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iStart(iStart),
    .iAbort(iAbort),
    .iNumSteps(iNumSteps),
    .iResRdy(iResRdy),
    .iIntRdy(iIntRdy),
    .oEnReserv(oEnReserv),
    .oEnInterpreter(oEnInterpreter),
    .oStage(oStage),
    .oStep(oStep),
    .oBusy(oBusy),
    .oDone(oDone),
    .oTimeout(oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    iNumSteps = n;
    iStart    = 1'b1;
    tick();
    iStart    = 1'b0;
  endtask

  task automatic pulse_res(input int k);
    iResRdy = 2'(1 << k);
    tick();
    iResRdy = 2'b00;
  endtask

  task automatic pulse_int();
    iIntRdy = 1'b1;
    tick();
    iIntRdy = 1'b0;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iStart = 1'b0; iAbort = 1'b0; iNumSteps = '0; iResRdy = '0; iIntRdy = 1'b0;
    #3;
    checks++;
    if ({oEnReserv, oEnInterpreter, oStage, oStep, oBusy, oDone, oTimeout} !== 23'd0)
      begin errors++; $display("FAIL reset_state: got %h want 0",
        {oEnReserv, oEnInterpreter, oStage, oStep, oBusy, oDone, oTimeout}); end
    tick();
    iRst_n = 1'b1;
    tick();
    checks++;
    if ({oEnReserv, oEnInterpreter, oBusy, oDone} !== 5'd0)
      begin errors++; $display("FAIL reset_idle: got %b want 0", {oEnReserv, oEnInterpreter, oBusy, oDone}); end
  endtask

  task automatic test_run3();
    logic [1:0] exp_res;
    logic       exp_int;
    logic       exp_stage;
    do_start(16'd3);
    for (int s = 0; s < 3; s++) begin
      for (int u = 0; u < 3; u++) begin
        exp_res   = (u == 0) ? 2'b01 : (u == 1) ? 2'b10 : 2'b00;
        exp_int   = (u == 2);
        exp_stage = (u != 0);
        checks++;
        if ({oEnReserv, oEnInterpreter, oStage, oStep, oBusy, oDone} !== {exp_res, exp_int, exp_stage, 16'(s), 1'b1, 1'b0})
          begin errors++; $display("FAIL run3_enter s%0d u%0d: got en=%b int=%b stg=%b step=%0d busy=%b done=%b want en=%b int=%b stg=%b step=%0d",
            s, u, oEnReserv, oEnInterpreter, oStage, oStep, oBusy, oDone, exp_res, exp_int, exp_stage, s); end
        tick();
        checks++;
        if ({oEnReserv, oEnInterpreter} !== {exp_res, exp_int})
          begin errors++; $display("FAIL run3_hold s%0d u%0d: got en=%b int=%b want en=%b int=%b",
            s, u, oEnReserv, oEnInterpreter, exp_res, exp_int); end
        tick();
        if (u == 2) iIntRdy = 1'b1;
        else        iResRdy = exp_res;
        tick();
        iIntRdy = 1'b0;
        iResRdy = 2'b00;
      end
    end
    checks++;
    if ({oEnReserv, oEnInterpreter, oBusy, oDone, oStep} !== {2'b00, 1'b0, 1'b0, 1'b1, 16'd2})
      begin errors++; $display("FAIL run3_done: got en=%b int=%b busy=%b done=%b step=%0d want en=00 int=0 busy=0 done=1 step=2",
        oEnReserv, oEnInterpreter, oBusy, oDone, oStep); end
    tick();
    checks++;
    if ({oBusy, oDone, oEnReserv, oEnInterpreter, oStep} !== {1'b0, 1'b0, 2'b00, 1'b0, 16'd2})
      begin errors++; $display("FAIL run3_after: got busy=%b done=%b en=%b int=%b step=%0d want all 0 step=2",
        oBusy, oDone, oEnReserv, oEnInterpreter, oStep); end
  endtask

  task automatic test_zero_steps();
    do_start(16'd0);
    checks++;
    if ({oDone, oBusy, oEnReserv, oEnInterpreter} !== 5'b10000)
      begin errors++; $display("FAIL zero_done: got done=%b busy=%b en=%b int=%b want done=1 rest 0",
        oDone, oBusy, oEnReserv, oEnInterpreter); end
    tick();
    checks++;
    if ({oDone, oBusy, oEnReserv, oEnInterpreter} !== 5'b00000)
      begin errors++; $display("FAIL zero_after: got done=%b busy=%b en=%b int=%b want all 0",
        oDone, oBusy, oEnReserv, oEnInterpreter); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_start(16'd2);
    pulse_res(0);
    // Leave R0's ready high while R1 waits: only the awaited bit may count.
    iResRdy = 2'b01;
    cnt = 0;
    for (int i = 0; i < 40 && oEnReserv == 2'b10; i++) begin
      cnt++;
      tick();
    end
    iResRdy = 2'b00;
    checks++;
    if (cnt != 15)
      begin errors++; $display("FAIL timeout_len: got %0d cycles want 15", cnt); end
    checks++;
    if ({oEnReserv, oEnInterpreter, oBusy, oTimeout, oDone} !== 5'b00010)
      begin errors++; $display("FAIL timeout_err: got en=%b int=%b busy=%b to=%b done=%b want en=00 int=0 busy=0 to=1 done=0",
        oEnReserv, oEnInterpreter, oBusy, oTimeout, oDone); end
    tick(); tick();
    checks++;
    if (oTimeout !== 1'b1)
      begin errors++; $display("FAIL timeout_sticky: got %b want 1", oTimeout); end
    do_start(16'd1);
    checks++;
    if ({oTimeout, oEnReserv, oStep, oBusy} !== {1'b0, 2'b01, 16'd0, 1'b1})
      begin errors++; $display("FAIL timeout_restart: got to=%b en=%b step=%0d busy=%b want to=0 en=01 step=0 busy=1",
        oTimeout, oEnReserv, oStep, oBusy); end
    pulse_res(0);
    pulse_res(1);
    pulse_int();
    checks++;
    if (oDone !== 1'b1)
      begin errors++; $display("FAIL timeout_rerun_done: got %b want 1", oDone); end
    tick();
  endtask

  task automatic test_expiry_ready();
    do_start(16'd1);
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if ({oEnReserv, oTimeout} !== 3'b010)
      begin errors++; $display("FAIL expiry_cycle15: got en=%b to=%b want en=01 to=0", oEnReserv, oTimeout); end
    pulse_res(0);
    checks++;
    if ({oEnReserv, oTimeout, oBusy, oStage} !== 5'b10011)
      begin errors++; $display("FAIL expiry_ready: got en=%b to=%b busy=%b stg=%b want en=10 to=0 busy=1 stg=1",
        oEnReserv, oTimeout, oBusy, oStage); end
    pulse_res(1);
    pulse_int();
    checks++;
    if ({oDone, oTimeout} !== 2'b10)
      begin errors++; $display("FAIL expiry_done: got done=%b to=%b want done=1 to=0", oDone, oTimeout); end
    tick();
  endtask

  task automatic test_abort();
    do_start(16'd3);
    iNumSteps = 16'd0;
    iStart    = 1'b1;
    tick();
    iStart    = 1'b0;
    iNumSteps = 16'd3;
    checks++;
    if ({oEnReserv, oBusy, oDone, oStep} !== {2'b01, 1'b1, 1'b0, 16'd0})
      begin errors++; $display("FAIL abort_busy_start: got en=%b busy=%b done=%b step=%0d want en=01 busy=1 done=0 step=0",
        oEnReserv, oBusy, oDone, oStep); end
    pulse_res(0); pulse_res(1); pulse_int();
    pulse_res(0); pulse_res(1);
    checks++;
    if ({oEnInterpreter, oStep} !== {1'b1, 16'd1})
      begin errors++; $display("FAIL abort_pre: got int=%b step=%0d want int=1 step=1", oEnInterpreter, oStep); end
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    checks++;
    if ({oEnReserv, oEnInterpreter, oBusy, oDone, oStep, oStage} !== {2'b00, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1})
      begin errors++; $display("FAIL abort_interp: got en=%b int=%b busy=%b done=%b step=%0d stg=%b want en=00 int=0 busy=0 done=0 step=1 stg=1",
        oEnReserv, oEnInterpreter, oBusy, oDone, oStep, oStage); end
    tick();
    checks++;
    if ({oDone, oBusy} !== 2'b00)
      begin errors++; $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", oDone, oBusy); end
    // Start and abort together in IDLE: the start wins.
    iAbort = 1'b1;
    do_start(16'd1);
    checks++;
    if ({oEnReserv, oBusy, oStep} !== {2'b01, 1'b1, 16'd0})
      begin errors++; $display("FAIL abort_start_idle: got en=%b busy=%b step=%0d want en=01 busy=1 step=0",
        oEnReserv, oBusy, oStep); end
    tick();
    iAbort = 1'b0;
    checks++;
    if ({oEnReserv, oBusy, oDone} !== 4'b0000)
      begin errors++; $display("FAIL abort_res: got en=%b busy=%b done=%b want all 0", oEnReserv, oBusy, oDone); end
  endtask

  task automatic test_reset_mid();
    do_start(16'd8);
    for (int s = 0; s < 5; s++) begin
      pulse_res(0); pulse_res(1); pulse_int();
    end
    pulse_res(0);
    checks++;
    if ({oEnReserv, oStep} !== {2'b10, 16'd5})
      begin errors++; $display("FAIL midrst_pre: got en=%b step=%0d want en=10 step=5", oEnReserv, oStep); end
    #2;
    iRst_n = 1'b0;
    #1;
    checks++;
    if ({oEnReserv, oEnInterpreter, oStage, oStep, oBusy, oDone, oTimeout} !== 23'd0)
      begin errors++; $display("FAIL midrst_async: got en=%b int=%b stg=%b step=%0d busy=%b done=%b to=%b want all 0",
        oEnReserv, oEnInterpreter, oStage, oStep, oBusy, oDone, oTimeout); end
    #2;
    iRst_n = 1'b1;
    tick();
    do_start(16'd1);
    checks++;
    if ({oEnReserv, oStep, oBusy, oStage} !== {2'b01, 16'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL midrst_restart: got en=%b step=%0d busy=%b stg=%b want en=01 step=0 busy=1 stg=0",
        oEnReserv, oStep, oBusy, oStage); end
    pulse_res(0); pulse_res(1); pulse_int();
    checks++;
    if ({oDone, oStep} !== {1'b1, 16'd0})
      begin errors++; $display("FAIL midrst_done: got done=%b step=%0d want done=1 step=0", oDone, oStep); end
    tick();
  endtask

  initial begin
    test_reset();
    test_run3();
    test_zero_steps();
    test_timeout();
    test_expiry_ready();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
